// File: rtl/sysregs_6502.sv
`timescale 1ns/1ps
// sysregs_6502: one-page memory-mapped system register block: boot/SPI/icache CSR, UPA masks, GPIO bank with rising-edge capture, interval timer, level IRQ.
// Optional macro SYSREGS_GPIO_SYNC_EN inserts a 2-flop synchroniser on gpio_in.
module sysregs_6502 #(
  parameter logic [7:0]  BASE_PAGE   = 8'hDF,
  parameter int unsigned NUM_GPIO    = 4,
  parameter int unsigned TIMER_WIDTH = 16,
  parameter int unsigned ENABLE_UPA  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         cpu_addr,
  input  logic                cpu_en,
  input  logic                cpu_wr,
  input  logic [7:0]          cpu_wdata,
  input  logic                cpu_rdy,
  output logic                int_en,
  output logic [7:0]          int_rdata,
  output logic                icache_en,
  output logic                skip_int,
  output logic                spi_phase,
  output logic                spi_delay,
  output logic                spi_fast,
  output logic [7:0]          upad,
  output logic [7:0]          upai,
  output logic [7:0]          upazo,
  input  logic [7:0]          gpin,
  output logic [7:0]          gpout,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic                irq
);

  localparam int unsigned GW = NUM_GPIO;
  localparam int unsigned TW = TIMER_WIDTH;

  logic [3:0]    off;
  logic          wr_stb;
  logic          rd_stb;
  logic          unused_addr;

  logic          first;
  logic [7:0]    csr;
  logic [7:0]    upad_q;
  logic [7:0]    upai_q;
  logic [7:0]    upazo_q;
  logic [7:0]    gpout_q;
  logic [GW-1:0] oe_q;
  logic [GW-1:0] out_q;
  logic [GW-1:0] rise_en;
  logic [GW-1:0] gpio_stat;
  logic [GW-1:0] gpio_prev;
  logic [GW-1:0] gpio_s;
  logic [GW-1:0] stat_set;
  logic [GW-1:0] stat_clr;

  logic          tmr_run;
  logic          tmr_auto;
  logic          tmr_fired;
  logic [TW-1:0] count;
  logic [TW-1:0] reload;
  logic [15:0]   count_ext;
  logic [15:0]   reload_ext;
  logic [7:0]    hi_shadow;
  logic          tmr_wr;

  // Address decode; the page aliases the 16-register map across addr[7:4].
  assign off         = cpu_addr[3:0];
  assign unused_addr = ^cpu_addr[7:4];
  assign int_en      = (cpu_addr[15:8] == BASE_PAGE);
  assign wr_stb      = int_en & cpu_en & cpu_rdy & cpu_wr;
  assign rd_stb      = int_en & cpu_en & cpu_rdy & ~cpu_wr;
  assign tmr_wr      = wr_stb && (off == 4'hB);

`ifdef SYSREGS_GPIO_SYNC_EN
  logic [GW-1:0] sync1;
  logic [GW-1:0] sync2;

  // Two-flop synchroniser for asynchronous pad inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end
  assign gpio_s = sync2;
`else
  assign gpio_s = gpio_in;
`endif

  assign stat_set   = gpio_s & ~gpio_prev & rise_en;
  assign stat_clr   = (wr_stb && (off == 4'hA)) ? GW'(cpu_wdata) : '0;
  assign count_ext  = 16'(count);
  assign reload_ext = 16'(reload);

  // CSR-driven outputs; a write to UPAI drops icache_en for that cycle.
  assign icache_en = csr[0] & ~(wr_stb && (off == 4'h2));
  assign skip_int  = csr[1];
  assign spi_phase = csr[2];
  assign spi_delay = csr[3];
  assign spi_fast  = csr[4];
  assign upad      = (ENABLE_UPA != 0) ? upad_q  : 8'h00;
  assign upai      = (ENABLE_UPA != 0) ? upai_q  : 8'h00;
  assign upazo     = (ENABLE_UPA != 0) ? upazo_q : 8'h00;
  assign gpout     = gpout_q;
  assign gpio_oe   = oe_q;
  assign gpio_out  = out_q;

  // Read mux, combinational and independent of int_en.
  always_comb begin
    int_rdata = 8'h00;
    case (off)
      4'h0: int_rdata = csr;
      4'h1: int_rdata = upad_q;
      4'h2: int_rdata = upai_q;
      4'h3: int_rdata = upazo_q;
      4'h4: int_rdata = gpin;
      4'h5: int_rdata = gpout_q;
      4'h6: int_rdata = 8'(gpio_s);
      4'h7: int_rdata = 8'(oe_q);
      4'h8: int_rdata = 8'(out_q);
      4'h9: int_rdata = 8'(rise_en);
      4'hA: int_rdata = 8'(gpio_stat);
      4'hB: int_rdata = {5'b00000, tmr_fired, tmr_auto, tmr_run};
      4'hC: int_rdata = count_ext[7:0];
      4'hD: int_rdata = hi_shadow;
      default: int_rdata = 8'h00;
    endcase
  end

  // Register file, GPIO capture, timer and IRQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first     <= 1'b1;
      csr       <= 8'h00;
      upad_q    <= 8'h00;
      upai_q    <= 8'h00;
      upazo_q   <= 8'h00;
      gpout_q   <= 8'h00;
      oe_q      <= '0;
      out_q     <= '0;
      rise_en   <= '0;
      gpio_stat <= '0;
      gpio_prev <= '0;
      tmr_run   <= 1'b0;
      tmr_auto  <= 1'b0;
      tmr_fired <= 1'b0;
      count     <= '0;
      reload    <= '0;
      hi_shadow <= 8'h00;
      irq       <= 1'b0;
    end else if (first) begin
      // Boot cycle: sample straps and seed edge history only.
      first     <= 1'b0;
      csr[4:0]  <= gpin[4:0];
      gpio_prev <= gpio_s;
    end else begin
      if (wr_stb) begin
        case (off)
          4'h0: csr     <= cpu_wdata;
          4'h1: upad_q  <= cpu_wdata;
          4'h2: upai_q  <= cpu_wdata;
          4'h3: upazo_q <= cpu_wdata;
          4'h5: gpout_q <= cpu_wdata;
          4'h7: oe_q    <= GW'(cpu_wdata);
          4'h8: out_q   <= GW'(cpu_wdata);
          4'h9: rise_en <= GW'(cpu_wdata);
          4'hC: reload  <= TW'({reload_ext[15:8], cpu_wdata});
          4'hD: reload  <= TW'({cpu_wdata, reload_ext[7:0]});
          default: ;
        endcase
      end

      gpio_prev <= gpio_s;
      gpio_stat <= (gpio_stat & ~stat_clr) | stat_set;

      if (rd_stb && (off == 4'hC)) begin
        hi_shadow <= count_ext[15:8];
      end

      // A control write pauses the countdown for one cycle and optionally reloads.
      if (tmr_wr) begin
        tmr_run   <= cpu_wdata[0];
        tmr_auto  <= cpu_wdata[1];
        tmr_fired <= tmr_fired & ~cpu_wdata[2];
        if (cpu_wdata[0]) begin
          count <= reload;
        end
      end else if (tmr_run) begin
        if (count != '0) begin
          count <= count - TW'(1);
        end else begin
          tmr_fired <= 1'b1;
          if (tmr_auto) begin
            count <= reload;
          end else begin
            tmr_run <= 1'b0;
          end
        end
      end

      irq <= (csr[5] & tmr_fired) | (csr[6] & (|gpio_stat));
    end
  end

endmodule

// File: tb/tb_sysregs_6502.sv
`timescale 1ns/1ps
// Scoreboard bench for sysregs_6502: stimulus queues expected read data and pin values; a negedge monitor compares.
module tb_sysregs_6502;

  localparam int S_ICACHE    = 0;
  localparam int S_SPI_PHASE = 1;
  localparam int S_SPI_FAST  = 2;
  localparam int S_UPAI      = 3;
  localparam int S_IRQ       = 4;
  localparam int S_NU_UPAI   = 5;
  localparam int S_NU_RDATA  = 6;
  localparam int S_GPOUT     = 7;
  localparam int S_SKIP      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_en, cpu_wr, cpu_rdy;
  logic [7:0]  cpu_wdata;
  logic [7:0]  gpin;
  logic [3:0]  gpio_in;

  logic        int_en, icache_en, skip_int, spi_phase, spi_delay, spi_fast, irq;
  logic [7:0]  int_rdata, upad, upai, upazo, gpout;
  logic [3:0]  gpio_oe, gpio_out;

  logic        n_int_en, n_icache_en, n_skip_int, n_spi_phase, n_spi_delay, n_spi_fast, n_irq;
  logic [7:0]  n_int_rdata, n_upad, n_upai, n_upazo, n_gpout;
  logic [3:0]  n_gpio_oe, n_gpio_out;

  sysregs_6502 #(.BASE_PAGE(8'hDF), .NUM_GPIO(4), .TIMER_WIDTH(16), .ENABLE_UPA(1)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy), .int_en(int_en), .int_rdata(int_rdata),
    .icache_en(icache_en), .skip_int(skip_int), .spi_phase(spi_phase), .spi_delay(spi_delay),
    .spi_fast(spi_fast), .upad(upad), .upai(upai), .upazo(upazo), .gpin(gpin), .gpout(gpout),
    .gpio_in(gpio_in), .gpio_oe(gpio_oe), .gpio_out(gpio_out), .irq(irq)
  );

  sysregs_6502 #(.BASE_PAGE(8'hDF), .NUM_GPIO(4), .TIMER_WIDTH(16), .ENABLE_UPA(0)) u_noupa (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy), .int_en(n_int_en), .int_rdata(n_int_rdata),
    .icache_en(n_icache_en), .skip_int(n_skip_int), .spi_phase(n_spi_phase), .spi_delay(n_spi_delay),
    .spi_fast(n_spi_fast), .upad(n_upad), .upai(n_upai), .upazo(n_upazo), .gpin(gpin), .gpout(n_gpout),
    .gpio_in(gpio_in), .gpio_oe(n_gpio_oe), .gpio_out(n_gpio_out), .irq(n_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } rd_t;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } pin_t;

  rd_t  rd_q[$];
  pin_t pin_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [7:0] pin_val(input int sel);
    case (sel)
      S_ICACHE:    return {7'd0, icache_en};
      S_SPI_PHASE: return {7'd0, spi_phase};
      S_SPI_FAST:  return {7'd0, spi_fast};
      S_UPAI:      return upai;
      S_IRQ:       return {7'd0, irq};
      S_NU_UPAI:   return n_upai;
      S_NU_RDATA:  return n_int_rdata;
      S_GPOUT:     return gpout;
      S_SKIP:      return {7'd0, skip_int};
      default:     return 8'hxx;
    endcase
  endfunction

  // Monitor: a bus read strobe pops read data; queued pin checks are taken in the same half cycle.
  rd_t  r;
  pin_t p;
  logic [7:0] act;
  always @(negedge clk) begin
    if (cpu_en && !cpu_wr && cpu_rdy && int_en) begin
      n_vec++;
      if (rd_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read addr=%h rdata=%h", cpu_addr, int_rdata);
      end else begin
        r = rd_q.pop_front();
        if (int_rdata !== r.exp) begin
          n_err++;
          $display("FAIL %s: rdata=%h expected %h", r.name, int_rdata, r.exp);
        end
      end
    end
    while (pin_q.size() > 0) begin
      p = pin_q.pop_front();
      act = pin_val(p.sel);
      n_vec++;
      if (act !== p.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", p.name, act, p.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr    = 1'b1;
    cpu_en    = 1'b1;
    tick();
    cpu_en    = 1'b0;
    cpu_wr    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string n);
    cpu_addr = a;
    cpu_wr   = 1'b0;
    cpu_en   = 1'b1;
    rd_q.push_back('{name: n, exp: e});
    tick();
    cpu_en   = 1'b0;
  endtask

  task automatic pin(input int s, input logic [7:0] e, input string n);
    pin_q.push_back('{name: n, sel: s, exp: e});
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; gpin = 8'h15; gpio_in = 4'h0;
    cpu_addr = 16'h0000; cpu_en = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00; cpu_rdy = 1'b1;
    #2;
    tick();
    pin(S_IRQ, 8'h00, "rst_irq");
    pin(S_ICACHE, 8'h00, "rst_icache");
    rd(16'hDF00, 8'h00, "rst_csr");
    rst = 1'b0;

    // Boot cycle: straps load CSR, write ignored
    wr(16'hDF00, 8'hFF);
    rd(16'hDF00, 8'h15, "first_csr");
    pin(S_ICACHE, 8'h01, "boot_icache");
    pin(S_SPI_PHASE, 8'h01, "boot_spi_phase");
    pin(S_SPI_FAST, 8'h01, "boot_spi_fast");
    pin(S_SKIP, 8'h00, "boot_skip_int");
    rd(16'hDF04, 8'h15, "gpin_ro");

    // UPAI write drops icache_en only in its own cycle
    cpu_addr = 16'hDF02; cpu_wdata = 8'hAA; cpu_wr = 1'b1; cpu_en = 1'b1;
    pin(S_ICACHE, 8'h00, "icache_wr2");
    tick();
    cpu_en = 1'b0; cpu_wr = 1'b0;
    pin(S_ICACHE, 8'h01, "icache_after_wr2");
    pin(S_UPAI, 8'hAA, "upai_out");
    pin(S_NU_UPAI, 8'h00, "noupa_upai_out");
    cpu_addr = 16'hDF02;
    pin(S_NU_RDATA, 8'hAA, "noupa_upai_rd");
    rd(16'hDF02, 8'hAA, "upai_rd");
    wr(16'hDE02, 8'h11);
    rd(16'hDF02, 8'hAA, "page_miss_wr");
    wr(16'hDF05, 8'h5A);
    pin(S_GPOUT, 8'h5A, "gpout_out");
    rd(16'hDF05, 8'h5A, "gpout_rd");
    wr(16'hDF07, 8'hFF);
    rd(16'hDF07, 8'h0F, "gpio_oe_width");
    wr(16'hDF0E, 8'h77);
    rd(16'hDF0E, 8'h00, "unused_e");

    // GPIO rising-edge capture and IRQ
    wr(16'hDF09, 8'h01);
    wr(16'hDF00, 8'h55);
    gpio_in = 4'h1;
    tick();
    pin(S_IRQ, 8'h00, "irq_latency");
    tick();
    pin(S_IRQ, 8'h01, "irq_gpio_set");
    rd(16'hDF0A, 8'h01, "stat_set");
    rd(16'hDF06, 8'h01, "gpio_in_rd");
    wr(16'hDF0A, 8'h01);
    rd(16'hDF0A, 8'h00, "stat_clr");
    pin(S_IRQ, 8'h00, "irq_gpio_clr");
    gpio_in = 4'h0;
    tick();
    cpu_addr = 16'hDF0A; cpu_wdata = 8'h01; cpu_wr = 1'b1; cpu_en = 1'b1; gpio_in = 4'h1;
    tick();
    cpu_en = 1'b0; cpu_wr = 1'b0;
    rd(16'hDF0A, 8'h01, "stat_set_wins");
    wr(16'hDF0A, 8'h01);
    rd(16'hDF0A, 8'h00, "stat_clr2");
    gpio_in = 4'h3;
    tick();
    rd(16'hDF0A, 8'h00, "rise_en_gate");
    wr(16'hDF00, 8'h15);

    // Timer one-shot then auto-reload
    wr(16'hDF0C, 8'h03);
    wr(16'hDF0D, 8'h00);
    wr(16'hDF0B, 8'h01);
    rd(16'hDF0C, 8'h03, "cnt3");
    rd(16'hDF0C, 8'h02, "cnt2");
    rd(16'hDF0C, 8'h01, "cnt1");
    rd(16'hDF0C, 8'h00, "cnt0");
    rd(16'hDF0B, 8'h04, "oneshot_fired");
    rd(16'hDF0C, 8'h00, "oneshot_hold0");
    wr(16'hDF0B, 8'h07);
    rd(16'hDF0B, 8'h03, "auto_ctrl");
    rd(16'hDF0C, 8'h02, "auto_cnt2");
    rd(16'hDF0C, 8'h01, "auto_cnt1");
    rd(16'hDF0C, 8'h00, "auto_cnt0");
    rd(16'hDF0B, 8'h07, "auto_refire");
    rd(16'hDF0C, 8'h02, "auto_reload");
    wr(16'hDF0B, 8'h04);
    rd(16'hDF0B, 8'h00, "timer_stop");

    // Coherent LO/HI read across a borrow
    wr(16'hDF0C, 8'h00);
    wr(16'hDF0D, 8'h01);
    wr(16'hDF0B, 8'h01);
    rd(16'hDF0C, 8'h00, "lo_0100");
    rd(16'hDF0D, 8'h01, "hi_shadow_01");
    rd(16'hDF0C, 8'hFE, "lo_00fe");
    rd(16'hDF0D, 8'h00, "hi_shadow_00");
    wr(16'hDF0B, 8'h04);

    // Timer IRQ, then asynchronous reset mid-count
    wr(16'hDF00, 8'h35);
    wr(16'hDF0C, 8'h03);
    wr(16'hDF0D, 8'h00);
    wr(16'hDF0B, 8'h01);
    rd(16'hDF0C, 8'h03, "t6_cnt3");
    rd(16'hDF0C, 8'h02, "t6_cnt2");
    rd(16'hDF0C, 8'h01, "t6_cnt1");
    rd(16'hDF0C, 8'h00, "t6_cnt0");
    pin(S_IRQ, 8'h00, "irq_tmr_latency");
    tick();
    pin(S_IRQ, 8'h01, "irq_tmr");
    wr(16'hDF0B, 8'h01);
    tick();
    #1;
    rst = 1'b1;
    pin(S_IRQ, 8'h00, "rst_async_irq");
    pin(S_ICACHE, 8'h00, "rst_async_csr");
    rd(16'hDF0B, 8'h00, "rst_async_ctrl");
    rd(16'hDF0C, 8'h00, "rst_async_count");
    rst = 1'b0;
    repeat (3) tick();

    n_vec++;
    if (rd_q.size() != 0 || pin_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: rd_q=%0d pin_q=%0d entries left, expected 0", rd_q.size(), pin_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sysregs_6502.md
Name: sysregs_6502

Overview:
Memory-mapped system register block for the 6502 SoC. It decodes one 256-byte page (default $DFxx) using a 16-register map and holds the boot and SPI/icache CSR and the UPA mask registers. Compared with the previous fixed register block it adds a parametrised GPIO bank with rising-edge capture, a down-counting interval timer with a coherent 16-bit read, and a combined level IRQ output to the CPU.

Parameters:
BASE_PAGE, 8'hDF, value of cpu_addr[15:8] that selects the block
NUM_GPIO, 4, GPIO channel count, legal range 1..8
TIMER_WIDTH, 16, timer counter width, legal range 8..16
ENABLE_UPA, 1, 0 ties the upad/upai/upazo outputs to 0 (registers remain readable)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_addr  in  16  CPU address
cpu_en  in  1  bus cycle valid
cpu_wr  in  1  1=write, 0=read
cpu_wdata  in  8  write data
cpu_rdy  in  1  CPU not stalled
int_en  out  1  page hit, combinational
int_rdata  out  8  read data, combinational from addr[3:0]
icache_en, skip_int, spi_phase, spi_delay, spi_fast  out  1 each  CSR[4:0]
upad, upai, upazo  out  8 each  UPA masks
gpin  in  8  board straps / general input
gpout  out  8  general output
gpio_in  in  NUM_GPIO  GPIO pads in
gpio_oe  out  NUM_GPIO  GPIO output enables
gpio_out  out  NUM_GPIO  GPIO pads out
irq  out  1  level interrupt, registered

Behaviour:
- int_en = (cpu_addr[15:8]==BASE_PAGE).
- wr_stb = int_en & cpu_en & cpu_rdy & cpu_wr.
- rd_stb = int_en & cpu_en & cpu_rdy & ~cpu_wr.
- All registers and irq clear asynchronously on rst.
- first flag: set by rst, cleared on the first clk after release. In the first cycle:
  - CSR[4:0] <= gpin[4:0]
  - gpio_prev <= gpio_in
  - no other register changes; writes in that cycle are ignored.
- Map, offset addr[3:0]; reads of unused bits return 0:
  - 0 CSR, RW. Bits [4:0] drive the outputs listed above. [5] TMR_IE. [6] GPIO_IE. [7] spare RW.
  - 1 UPAD, 2 UPAI, 3 UPAZO: RW.
  - A write to offset 2 forces icache_en=0 combinationally during that cycle.
  - 4 gpin, RO. 5 GPOUT, RW.
  - 6 gpio_in, RO, zero-extended. 7 GPIO_OE, RW. 8 GPIO_OUT, RW.
  - 9 RISE_EN, RW: per-channel capture enable.
  - A GPIO_STAT, W1C: bit i sets when gpio_in[i] & ~gpio_prev[i] & RISE_EN[i]. gpio_prev updates every cycle. Set wins over a same-cycle clear.
  - B TMR_CTRL:
    - [0] RUN, RW.
    - [1] AUTO, RW.
    - [2] FIRED, W1C; set wins over a same-cycle clear.
    - A write with RUN=1 loads count <= reload in that cycle.
  - C TMR_LO / D TMR_HI:
    - Writes go to reload[7:0] / reload[TIMER_WIDTH-1:8].
    - Reading C returns count[7:0] and latches count high bits into hi_shadow on rd_stb.
    - Reading D returns hi_shadow, so a LO-then-HI read pair is coherent.
  - E, F: read 0, writes ignored.
- Timer, per clk while RUN=1 and no TMR_CTRL write this cycle:
  - count != 0: count <= count-1.
  - count == 0: FIRED <= 1. If AUTO=1, count <= reload and RUN stays 1. If AUTO=0, RUN <= 0 and count holds at 0.
  - reload=0 with AUTO=1 sets FIRED every cycle.
  - Arithmetic is modulo TIMER_WIDTH; no underflow past 0.
- irq <= (CSR[5] & FIRED) | (CSR[6] & |GPIO_STAT). One cycle latency from the status bit to irq.
- Read data is combinational. int_rdata is valid whenever cpu_addr is valid, regardless of int_en.

Optional Feature:
- Macro: SYSREGS_GPIO_SYNC_EN.
- Defined: gpio_in passes through a 2-flop synchroniser, reset 0. Edge detect and the offset-6 read use the synchronised value; edge capture latency becomes 3 cycles after the pad change.
- Undefined: gpio_in is used directly; edge capture latency is 1 cycle.

Test Plan:
1. Reset with gpin=8'h15, then release -> after the first clk, CSR reads 8'h15: icache_en=1, spi_phase=1, spi_fast=1. A write to CSR in that first cycle has no effect.
2. Write $DF02=8'hAA -> icache_en is 0 during the write cycle only. upai=8'hAA the next cycle; with ENABLE_UPA=0, upai=0 but $DF02 reads 8'hAA.
3. RISE_EN=8'h01, drive gpio_in[0] 0->1 -> GPIO_STAT=8'h01. With CSR[6]=1, irq=1 one cycle later. Write 8'h01 to $DF0A -> irq=0. A new edge in the clear cycle keeps the bit set.
4. reload=16'h0003, CTRL=8'h01 (one-shot) -> count goes 3,2,1,0, then FIRED=1 and RUN=0, count stays 0. With AUTO=1, FIRED is set every 4 cycles.
5. Counter at 16'h0100: read $DF0C -> 8'h00. Let the counter tick to 16'h00FF, then read $DF0D -> 8'h01 (shadowed, not 8'h00).
6. Assert rst mid-count with FIRED=1 -> irq, count and CTRL are 0 immediately, asynchronously.
